// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control path.
// Holds the opcode/funct encodings, ALU and destination-select codes, the ID/EX control
// bundle layout (field indices, width, bubble value), the narrower per-stage control
// structs used by EX/MEM and MEM/WB, and a helper that packs a valid bundle.
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes (zero-extended to ALUCTRL_W at the output)
    localparam int unsigned ALU_CODE_W = 3;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Destination register select
    localparam logic [1:0] RFD_RT  = 2'b00;
    localparam logic [1:0] RFD_RD  = 2'b01;
    localparam logic [1:0] RFD_R31 = 2'b10;

    // ID/EX bundle layout
    localparam int unsigned B_VALID      = 0;
    localparam int unsigned B_RFWE       = 1;
    localparam int unsigned B_MTORF      = 2;
    localparam int unsigned B_DMWE       = 3;
    localparam int unsigned B_ALUINSEL   = 4;
    localparam int unsigned B_LINK       = 5;
    localparam int unsigned B_RFDSEL_LSB = 6;
    localparam int unsigned B_ALU_LSB    = 8;
    localparam int unsigned BUNDLE_W     = 11;

    localparam logic [BUNDLE_W-1:0] BUBBLE = '0;

    // Later stages only carry the fields still consumed downstream.
    typedef struct packed {
        logic link;
        logic dmwe;
        logic mtorf;
        logic rfwe;
        logic valid;
    } mem_ctrl_t;

    typedef struct packed {
        logic link;
        logic mtorf;
        logic rfwe;
        logic valid;
    } wb_ctrl_t;

    function automatic logic [BUNDLE_W-1:0] make_bundle(
        input logic       rfwe,
        input logic       mtorf,
        input logic       dmwe,
        input logic       alu_in_sel,
        input logic       link,
        input logic [1:0] rfd_sel,
        input logic [2:0] alu
    );
        return {alu, rfd_sel, link, alu_in_sel, dmwe, mtorf, rfwe, 1'b1};
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational main decoder + ALU decoder for the ID stage.
// Ports:
//   opcode_i, funct_i  instruction fields in ID
//   bundle_o           valid control bundle, or BUBBLE for unknown encodings
//   jump_o, branch_o, branch_ne_o, zero_ext_o   ID-only control
//   illegal_o          unknown opcode/funct (or extension opcode with EN_EXT=0)
module control_decoder
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_EXT = 1'b1
) (
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          funct_i,
    output logic [BUNDLE_W-1:0] bundle_o,
    output logic                jump_o,
    output logic                branch_o,
    output logic                branch_ne_o,
    output logic                zero_ext_o,
    output logic                illegal_o
);

    logic [2:0] r_alu;

    // Default is the illegal bubble so no encoding ever produces x.
    always_comb begin
        bundle_o    = BUBBLE;
        illegal_o   = 1'b1;
        jump_o      = 1'b0;
        branch_o    = 1'b0;
        branch_ne_o = 1'b0;
        zero_ext_o  = 1'b0;
        r_alu       = ALU_ADD;
        case (opcode_i)
            OP_LW: begin
                bundle_o  = make_bundle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RFD_RT, ALU_ADD);
                illegal_o = 1'b0;
            end
            OP_SW: begin
                bundle_o  = make_bundle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, RFD_RT, ALU_ADD);
                illegal_o = 1'b0;
            end
            OP_BEQ: begin
                bundle_o  = make_bundle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFD_RT, ALU_SUB);
                branch_o  = 1'b1;
                illegal_o = 1'b0;
            end
            OP_ADDI: begin
                bundle_o  = make_bundle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RFD_RT, ALU_ADD);
                illegal_o = 1'b0;
            end
            OP_J: begin
                bundle_o  = make_bundle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFD_RT, ALU_AND);
                jump_o    = 1'b1;
                illegal_o = 1'b0;
            end
            OP_RTYPE: begin
                illegal_o = 1'b0;
                case (funct_i)
                    FN_ADD:  r_alu = ALU_ADD;
                    FN_SUB:  r_alu = ALU_SUB;
                    FN_AND:  r_alu = ALU_AND;
                    FN_OR:   r_alu = ALU_OR;
                    FN_SLT:  r_alu = ALU_SLT;
                    default: illegal_o = 1'b1;
                endcase
                if (!illegal_o) begin
                    bundle_o = make_bundle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RFD_RD, r_alu);
                end
            end
            OP_ANDI, OP_ORI: begin
                if (EN_EXT) begin
                    r_alu      = (opcode_i == OP_ANDI) ? ALU_AND : ALU_OR;
                    bundle_o   = make_bundle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RFD_RT, r_alu);
                    zero_ext_o = 1'b1;
                    illegal_o  = 1'b0;
                end
            end
            OP_SLTI: begin
                if (EN_EXT) begin
                    bundle_o  = make_bundle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RFD_RT, ALU_SLT);
                    illegal_o = 1'b0;
                end
            end
            OP_BNE: begin
                if (EN_EXT) begin
                    bundle_o    = make_bundle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RFD_RT, ALU_SUB);
                    branch_ne_o = 1'b1;
                    illegal_o   = 1'b0;
                end
            end
            OP_JAL: begin
                if (EN_EXT) begin
                    bundle_o  = make_bundle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RFD_R31, ALU_AND);
                    jump_o    = 1'b1;
                    illegal_o = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes in ID and carries control through ID/EX, EX/MEM and
// MEM/WB with stall/flush bubbles, a sticky illegal-instruction flag and a retire counter.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   OpcodeD, FunctD             instruction fields in ID
//   StallE, FlushE              hold / bubble the ID/EX register (flush wins)
//   JumpD..IllegalD             combinational ID decode
//   ALUCtrlE..RFWEE, MtoRFSelE  EX-stage control
//   RFWEM, MtoRFSelM, DMWEM     MEM-stage control
//   RFWEW, MtoRFSelW, LinkW     WB-stage control
//   IllegalFlag, RetiredCnt     status
module pipelined_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          EN_EXT    = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           OpcodeD,
    input  logic [5:0]           FunctD,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic                 JumpD,
    output logic                 BranchD,
    output logic                 BranchNED,
    output logic                 ZeroExtD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUCtrlE,
    output logic                 ALUInSelE,
    output logic [1:0]           RFDSelE,
    output logic                 RFWEE,
    output logic                 RFWEM,
    output logic                 RFWEW,
    output logic                 MtoRFSelE,
    output logic                 MtoRFSelM,
    output logic                 MtoRFSelW,
    output logic                 DMWEM,
    output logic                 LinkW,
    output logic                 IllegalFlag,
    output logic [CNT_W-1:0]     RetiredCnt
);

    logic [BUNDLE_W-1:0] dec_bundle;
    logic [BUNDLE_W-1:0] id_ex_d, id_ex_q;
    mem_ctrl_t           ex_mem_d, ex_mem_q;
    wb_ctrl_t            mem_wb_d, mem_wb_q;
    logic                flag_d, flag_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic                stall_eff;

    control_decoder #(
        .EN_EXT (EN_EXT)
    ) u_decoder (
        .opcode_i    (OpcodeD),
        .funct_i     (FunctD),
        .bundle_o    (dec_bundle),
        .jump_o      (JumpD),
        .branch_o    (BranchD),
        .branch_ne_o (BranchNED),
        .zero_ext_o  (ZeroExtD),
        .illegal_o   (IllegalD)
    );

    always_comb begin
        // A flush overrides the stall entirely, so EX/MEM keeps advancing.
        stall_eff = StallE && !FlushE;

        if (FlushE) begin
            id_ex_d = BUBBLE;
        end else if (StallE) begin
            id_ex_d = id_ex_q;
        end else begin
            id_ex_d = dec_bundle;
        end

        ex_mem_d = '0;
        if (!stall_eff) begin
            ex_mem_d.valid = id_ex_q[B_VALID];
            ex_mem_d.rfwe  = id_ex_q[B_RFWE];
            ex_mem_d.mtorf = id_ex_q[B_MTORF];
            ex_mem_d.dmwe  = id_ex_q[B_DMWE];
            ex_mem_d.link  = id_ex_q[B_LINK];
        end

        mem_wb_d.valid = ex_mem_q.valid;
        mem_wb_d.rfwe  = ex_mem_q.rfwe;
        mem_wb_d.mtorf = ex_mem_q.mtorf;
        mem_wb_d.link  = ex_mem_q.link;

        // Only an ID cycle that is actually accepted can flag an illegal instruction.
        flag_d = flag_q | (IllegalD & ~StallE & ~FlushE);
        cnt_d  = mem_wb_q.valid ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q  <= BUBBLE;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ALUCtrlE    = ALUCTRL_W'(id_ex_q[B_ALU_LSB +: ALU_CODE_W]);
    assign ALUInSelE   = id_ex_q[B_ALUINSEL];
    assign RFDSelE     = id_ex_q[B_RFDSEL_LSB +: 2];
    assign RFWEE       = id_ex_q[B_RFWE];
    assign MtoRFSelE   = id_ex_q[B_MTORF];
    assign RFWEM       = ex_mem_q.rfwe;
    assign MtoRFSelM   = ex_mem_q.mtorf;
    assign DMWEM       = ex_mem_q.dmwe;
    assign RFWEW       = mem_wb_q.rfwe;
    assign MtoRFSelW   = mem_wb_q.mtorf;
    assign LinkW       = mem_wb_q.link;
    assign IllegalFlag = flag_q;
    assign RetiredCnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit. Three instances share one stimulus stream:
// the default build, one with the extension opcodes disabled, and one with a 4-bit counter.
module tb_pipelined_control_unit;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, JAL = 6'b000011, ANDI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101, BNE = 6'b000101;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       stall, flush;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic        jump_d, branch_d, branch_ne_d, zero_ext_d, illegal_d;
    logic [2:0]  alu_e;
    logic        alu_in_sel_e, rfwe_e, rfwe_m, rfwe_w, mtorf_e, mtorf_m, mtorf_w;
    logic [1:0]  rfd_sel_e;
    logic        dmwe_m, link_w, flag;
    logic [31:0] cnt;

    // EN_EXT = 0 instance
    logic        jump_n, branch_n, branch_ne_n, zero_ext_n, illegal_n;
    logic [2:0]  alu_n;
    logic        alu_in_sel_n, rfwe_e_n, rfwe_m_n, rfwe_w_n, mtorf_e_n, mtorf_m_n, mtorf_w_n;
    logic [1:0]  rfd_sel_n;
    logic        dmwe_n, link_n, flag_n;
    logic [31:0] cnt_n;

    // CNT_W = 4 instance
    logic        jump_c, branch_c, branch_ne_c, zero_ext_c, illegal_c;
    logic [2:0]  alu_c;
    logic        alu_in_sel_c, rfwe_e_c, rfwe_m_c, rfwe_w_c, mtorf_e_c, mtorf_m_c, mtorf_w_c;
    logic [1:0]  rfd_sel_c;
    logic        dmwe_c, link_c, flag_c;
    logic [3:0]  cnt_c;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst_n(rst_n), .OpcodeD(opcode), .FunctD(funct),
        .StallE(stall), .FlushE(flush),
        .JumpD(jump_d), .BranchD(branch_d), .BranchNED(branch_ne_d), .ZeroExtD(zero_ext_d),
        .IllegalD(illegal_d), .ALUCtrlE(alu_e), .ALUInSelE(alu_in_sel_e), .RFDSelE(rfd_sel_e),
        .RFWEE(rfwe_e), .RFWEM(rfwe_m), .RFWEW(rfwe_w),
        .MtoRFSelE(mtorf_e), .MtoRFSelM(mtorf_m), .MtoRFSelW(mtorf_w),
        .DMWEM(dmwe_m), .LinkW(link_w), .IllegalFlag(flag), .RetiredCnt(cnt)
    );

    pipelined_control_unit #(.EN_EXT(1'b0)) dut_noext (
        .clk(clk), .rst_n(rst_n), .OpcodeD(opcode), .FunctD(funct),
        .StallE(stall), .FlushE(flush),
        .JumpD(jump_n), .BranchD(branch_n), .BranchNED(branch_ne_n), .ZeroExtD(zero_ext_n),
        .IllegalD(illegal_n), .ALUCtrlE(alu_n), .ALUInSelE(alu_in_sel_n), .RFDSelE(rfd_sel_n),
        .RFWEE(rfwe_e_n), .RFWEM(rfwe_m_n), .RFWEW(rfwe_w_n),
        .MtoRFSelE(mtorf_e_n), .MtoRFSelM(mtorf_m_n), .MtoRFSelW(mtorf_w_n),
        .DMWEM(dmwe_n), .LinkW(link_n), .IllegalFlag(flag_n), .RetiredCnt(cnt_n)
    );

    pipelined_control_unit #(.CNT_W(4)) dut_cnt4 (
        .clk(clk), .rst_n(rst_n), .OpcodeD(opcode), .FunctD(funct),
        .StallE(stall), .FlushE(flush),
        .JumpD(jump_c), .BranchD(branch_c), .BranchNED(branch_ne_c), .ZeroExtD(zero_ext_c),
        .IllegalD(illegal_c), .ALUCtrlE(alu_c), .ALUInSelE(alu_in_sel_c), .RFDSelE(rfd_sel_c),
        .RFWEE(rfwe_e_c), .RFWEM(rfwe_m_c), .RFWEW(rfwe_w_c),
        .MtoRFSelE(mtorf_e_c), .MtoRFSelM(mtorf_m_c), .MtoRFSelW(mtorf_w_c),
        .DMWEM(dmwe_c), .LinkW(link_c), .IllegalFlag(flag_c), .RetiredCnt(cnt_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = LW; funct = 6'd0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        chk("rst_rfwe_e", 32'(rfwe_e), 32'd0);
        chk("rst_alu_e", 32'(alu_e), 32'd0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_cnt", cnt, 32'd0);
        rst_n = 1'b1;

        // lw, sw, add, beq back-to-back
        opcode = LW; tick();                                   // edge 1
        chk("lw_rfwe_e", 32'(rfwe_e), 32'd1);
        chk("lw_mtorf_e", 32'(mtorf_e), 32'd1);
        chk("lw_alu_in_sel_e", 32'(alu_in_sel_e), 32'd1);
        chk("lw_alu_e", 32'(alu_e), 32'b010);
        opcode = SW; tick();                                   // edge 2
        chk("lw_rfwe_m", 32'(rfwe_m), 32'd1);
        chk("lw_mtorf_m", 32'(mtorf_m), 32'd1);
        opcode = RT; funct = F_ADD; tick();                    // edge 3
        chk("lw_rfwe_w", 32'(rfwe_w), 32'd1);
        chk("lw_mtorf_w", 32'(mtorf_w), 32'd1);
        chk("sw_dmwe_m", 32'(dmwe_m), 32'd1);
        chk("add_rfd_sel_e", 32'(rfd_sel_e), 32'b01);
        chk("add_alu_in_sel_e", 32'(alu_in_sel_e), 32'd0);
        opcode = BEQ; #1;
        chk("beq_branch_d", 32'(branch_d), 32'd1);
        chk("beq_jump_d", 32'(jump_d), 32'd0);
        tick();                                                // edge 4
        chk("beq_alu_e", 32'(alu_e), 32'b110);
        chk("beq_rfwe_e", 32'(rfwe_e), 32'd0);
        chk("cnt_1", cnt, 32'd1);

        // Flush with sw in ID (then with stall too): sw never reaches MEM
        flush = 1'b1; opcode = SW; tick();                     // edge 5
        chk("flush_rfwe_e", 32'(rfwe_e), 32'd0);
        chk("flush_dmwe_m_a", 32'(dmwe_m), 32'd0);
        chk("cnt_2", cnt, 32'd2);
        stall = 1'b1; tick();                                  // edge 6
        chk("flush_dmwe_m_b", 32'(dmwe_m), 32'd0);
        chk("cnt_3", cnt, 32'd3);
        stall = 1'b0; opcode = 6'b111111; #1;
        chk("bad_op_illegal_d", 32'(illegal_d), 32'd1);
        tick();                                                // edge 7
        chk("flush_dmwe_m_c", 32'(dmwe_m), 32'd0);
        chk("cnt_4", cnt, 32'd4);
        tick();                                                // edge 8
        chk("cnt_hold_4", cnt, 32'd4);
        chk("flush_illegal_flag", 32'(flag), 32'd0);
        chk("bubble_rfwe_w", 32'(rfwe_w), 32'd0);

        // R-type sub, then unknown funct
        flush = 1'b0; opcode = RT; funct = F_SUB; tick();      // edge 9
        chk("sub_alu_e", 32'(alu_e), 32'b110);
        chk("sub_rfd_sel_e", 32'(rfd_sel_e), 32'b01);
        chk("sub_rfwe_e", 32'(rfwe_e), 32'd1);
        funct = 6'b000111; #1;
        chk("bad_funct_illegal_d", 32'(illegal_d), 32'd1);
        chk("flag_not_yet", 32'(flag), 32'd0);
        tick();                                                // edge 10
        chk("bad_funct_flag", 32'(flag), 32'd1);
        chk("bad_funct_bubble_rfwe", 32'(rfwe_e), 32'd0);
        chk("bad_funct_bubble_alu", 32'(alu_e), 32'd0);

        // Stall two cycles on add
        funct = F_ADD; tick();                                 // edge 11
        chk("add_alu_e", 32'(alu_e), 32'b010);
        stall = 1'b1; opcode = SW; tick();                     // edge 12
        chk("stall1_alu_e", 32'(alu_e), 32'b010);
        chk("stall1_rfwe_e", 32'(rfwe_e), 32'd1);
        chk("stall1_rfwe_m", 32'(rfwe_m), 32'd0);
        tick();                                                // edge 13
        chk("stall2_alu_e", 32'(alu_e), 32'b010);
        chk("stall2_rfwe_m", 32'(rfwe_m), 32'd0);
        chk("stall2_dmwe_m", 32'(dmwe_m), 32'd0);
        stall = 1'b0; opcode = ADDI; tick();                   // edge 14
        chk("unstall_rfwe_m", 32'(rfwe_m), 32'd1);
        chk("addi_alu_in_sel_e", 32'(alu_in_sel_e), 32'd1);

        // Extension opcodes
        opcode = JAL; #1;
        chk("jal_jump_d", 32'(jump_d), 32'd1);
        chk("jal_illegal_d", 32'(illegal_d), 32'd0);
        chk("noext_jal_illegal_d", 32'(illegal_n), 32'd1);
        tick();                                                // edge 15
        chk("jal_rfd_sel_e", 32'(rfd_sel_e), 32'b10);
        chk("jal_rfwe_e", 32'(rfwe_e), 32'd1);
        opcode = ANDI; #1;
        chk("andi_zero_ext_d", 32'(zero_ext_d), 32'd1);
        chk("noext_andi_zero_ext", 32'(zero_ext_n), 32'd0);
        tick();                                                // edge 16
        chk("andi_alu_e", 32'(alu_e), 32'b000);
        chk("andi_alu_in_sel_e", 32'(alu_in_sel_e), 32'd1);
        opcode = BNE; #1;
        chk("bne_branch_ne_d", 32'(branch_ne_d), 32'd1);
        chk("bne_branch_d", 32'(branch_d), 32'd0);
        tick();                                                // edge 17
        chk("jal_link_w", 32'(link_w), 32'd1);
        chk("jal_rfwe_w", 32'(rfwe_w), 32'd1);
        chk("bne_alu_e", 32'(alu_e), 32'b110);
        opcode = ORI; tick();                                  // edge 18
        chk("ori_alu_e", 32'(alu_e), 32'b001);
        chk("andi_link_w", 32'(link_w), 32'd0);
        opcode = LW; tick();                                   // edge 19
        chk("lw2_mtorf_e", 32'(mtorf_e), 32'd1);

        // Asynchronous reset with lw in EX
        #2 rst_n = 1'b0; #1;
        chk("arst_rfwe_e", 32'(rfwe_e), 32'd0);
        chk("arst_mtorf_e", 32'(mtorf_e), 32'd0);
        chk("arst_alu_in_sel_e", 32'(alu_in_sel_e), 32'd0);
        chk("arst_rfwe_m", 32'(rfwe_m), 32'd0);
        chk("arst_flag", 32'(flag), 32'd0);
        chk("arst_cnt", cnt, 32'd0);
        chk("arst_cnt4", 32'(cnt_c), 32'd0);
        tick();
        chk("arst_hold_rfwe_e", 32'(rfwe_e), 32'd0);
        rst_n = 1'b1;

        // Continuous adds: retire n-3 after edge n; 4-bit counter wraps at 16
        opcode = RT; funct = F_ADD;
        repeat (19) tick();
        chk("cnt_16", cnt, 32'd16);
        chk("cnt4_wrap_0", 32'(cnt_c), 32'd0);
        tick();
        chk("cnt_17", cnt, 32'd17);
        chk("cnt4_17_is_1", 32'(cnt_c), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
